msrv32_fetch_queue: RTL
=======================

// Module: msrv32_fetch_queue
// PURPOSE
//  Instruction fetch stage feeding msrv32 decode. Generates sequential PCs, requests words from
//  instruction memory (one outstanding request), buffers returned words with their PC in a small
//  FIFO, and presents the head entry plus a flush flag to the instruction-decode mux. A flush
//  makes decode substitute a NOP (32'h00000013). Redirects from branch/trap logic discard
//  queued and in-flight fetches.
// PARAMETERS
//  DEPTH     2             FIFO entries; power of two, >= 2
//  RESET_PC  32'h0000_0000  first fetch address after reset; bits[1:0] must be 0
// PORTS
//  ms_riscv32_mp_clk_in          in   1   clock; all state on rising edge
//  ms_riscv32_mp_rst_in          in   1   reset, asynchronous assert, active-low
//  redirect_in                   in   1   branch/trap redirect this cycle
//  redirect_pc_in                in   32  new fetch PC; bits[1:0] ignored (forced 0)
//  stall_in                      in   1   decode cannot accept the head entry this cycle
//  ms_riscv32_mp_imaddr_out      out  32  instruction memory address (word aligned)
//  ms_riscv32_mp_imreq_out       out  1   fetch request valid
//  ms_riscv32_mp_instr_hready_in in   1   memory accepts request this cycle
//  ms_riscv32_mp_instr_in        in   32  read data, valid the cycle after acceptance
//  instr_out                     out  32  head-entry instruction; 32'h00000013 when empty
//  pc_out                        out  32  head-entry PC
//  flush_out                     out  1   1 = no valid instruction for decode (drives decode-mux flush_in)
// BEHAVIOUR
//  Reset (rst_in=0, async): FIFO empty, outstanding=0, drop=0, fetch_pc=RESET_PC, state=BOOT;
//   imreq_out=0, imaddr_out=RESET_PC, instr_out=32'h13, pc_out=RESET_PC, flush_out=1.
//  FSM: BOOT -> FETCH on first clock after reset release (no request in BOOT).
//   FETCH: imreq_out=1 iff (count + outstanding) < DEPTH; otherwise -> HOLD, imreq_out=0.
//   HOLD -> FETCH when a pop frees space. Redirect in any state -> FETCH.
//  imaddr_out = fetch_pc, held stable while imreq_out=1 and hready_in=0.
//  Accept = imreq_out & hready_in: fetch_pc <= fetch_pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0),
//   outstanding <= 1, and the accepted address is latched as resp_pc.
//  Response: the cycle after an accept, instr_in is pushed with resp_pc unless drop=1 or a
//   redirect occurs that cycle; outstanding clears unless a new accept occurs the same cycle
//   (back-to-back issue allowed, one word per cycle peak throughput).
//  Space check includes outstanding, so a push never hits a full FIFO; no overflow path.
//  Head: flush_out = empty; instr_out/pc_out = head entry (instr_out=32'h13 when empty).
//  Pop = !empty & !stall_in & !redirect_in. Push and pop in the same cycle keep count unchanged;
//   push into empty FIFO is visible at the head the next cycle (1-cycle buffer latency).
//  Redirect: same cycle flush_out forced 1; at the edge the FIFO is cleared, fetch_pc <=
//   {redirect_pc_in[31:2],2'b00}, and if a request was accepted this cycle or previous, drop <= 1
//   so its response is discarded. An unaccepted request is simply withdrawn (imreq may fall
//   without hready). Earliest new request: the cycle after redirect.
//  Redirect + accept same cycle: the accepted request belongs to the old stream and is dropped.
//  Redirect + response same cycle: response discarded.
//  Reset mid-transaction: in-flight response ignored (outstanding cleared).
//  Count/pointers: log2(DEPTH)-bit read/write pointers wrap naturally; count is
//   log2(DEPTH)+1 bits.
// TESTING
//  1 Reset release, hready=1, stall=0: imaddr 0,4,8,... on consecutive cycles; decode sees
//    PC 0 with flush_out=0 three cycles after reset release, then one instruction per cycle.
//  2 stall_in=1 held: exactly DEPTH words queued, imreq_out falls (HOLD); release stall ->
//    PCs 0,4 delivered in order, no duplicate or skipped PC.
//  3 hready=0 for 3 cycles with imaddr=8: address held at 8, no fetch_pc advance; then accepted.
//  4 redirect_in=1, redirect_pc_in=32'h0000_0102 while a response is in flight: flush_out=1 that
//    cycle, stale word never appears, next imaddr=32'h0000_0100, next decoded PC=32'h100.
//  5 RESET_PC=32'hFFFF_FFF8: fetch sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
//  6 Assert rst_in=0 mid-fetch: outputs return to reset values immediately (no clock);
//    queue empty after release.

Source files
------------

// File: rtl/msrv32_fetch_queue.sv
// Instruction fetch stage for msrv32: sequential PC generation, single-outstanding
// instruction memory requests, and a small PC/instruction FIFO feeding decode.
module msrv32_fetch_queue #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    input  logic        stall_in,
    output logic [31:0] ms_riscv32_mp_imaddr_out,
    output logic        ms_riscv32_mp_imreq_out,
    input  logic        ms_riscv32_mp_instr_hready_in,
    input  logic [31:0] ms_riscv32_mp_instr_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        flush_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]       state, state_next;
    logic [31:0]      fetch_pc, fetch_pc_next;
    logic [31:0]      resp_pc;
    logic             outstanding;
    logic             drop;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic [CNT_W-1:0] occupancy, occupancy_next;
    logic [31:0]      instr_mem [DEPTH];
    logic [31:0]      pc_mem    [DEPTH];
    logic             empty;
    logic             accept;
    logic             push;
    logic             pop;
    logic [31:0]      redirect_pc_aligned;
    logic             unused_pc_bits;

    assign redirect_pc_aligned = {redirect_pc_in[31:2], 2'b00};
    assign unused_pc_bits      = ^redirect_pc_in[1:0];

    assign empty     = (count == '0);
    // The in-flight word reserves a slot, so a response can never find the FIFO full.
    assign occupancy = count + CNT_W'(outstanding);

    assign ms_riscv32_mp_imreq_out  = (state == ST_FETCH) && (occupancy < DEPTH_C);
    assign ms_riscv32_mp_imaddr_out = fetch_pc;

    assign accept = ms_riscv32_mp_imreq_out & ms_riscv32_mp_instr_hready_in;
    assign push   = outstanding & ~drop & ~redirect_in;
    assign pop    = ~empty & ~stall_in & ~redirect_in;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_next = count;
        if (redirect_in) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
    end

    assign occupancy_next = count_next + CNT_W'(accept);

    always_comb begin
        state_next = state;
        if (redirect_in || (state == ST_BOOT)) begin
            state_next = ST_FETCH;
        end else if (occupancy_next >= DEPTH_C) begin
            state_next = ST_HOLD;
        end else begin
            state_next = ST_FETCH;
        end
    end

    always_comb begin
        fetch_pc_next = fetch_pc;
        if (redirect_in) begin
            fetch_pc_next = redirect_pc_aligned;
        end else if (accept) begin
            fetch_pc_next = fetch_pc + 32'd4;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state       <= ST_BOOT;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            outstanding <= accept;
            // Only a request accepted alongside a redirect belongs to the discarded stream.
            drop        <= redirect_in & accept;
            count       <= count_next;
            if (accept) begin
                resp_pc <= fetch_pc;
            end
            if (redirect_in) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // NOTE: FIFO storage is not reset; count alone decides which entries are valid.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (push) begin
            instr_mem[wr_ptr] <= ms_riscv32_mp_instr_in;
            pc_mem[wr_ptr]    <= resp_pc;
        end
    end

    assign flush_out = empty | redirect_in;
    assign instr_out = empty ? NOP : instr_mem[rd_ptr];
    assign pc_out    = empty ? fetch_pc : pc_mem[rd_ptr];

endmodule
